// File: rtl/quad_encoder_counter.sv
// Filtered 4x quadrature decoder: per-channel sync + deglitch, then a
// wrapping signed position counter with direction and error tracking.

// One encoder channel: 2-FF synchroniser followed by a persistence filter.
module qec_chan_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic filt
);
    localparam logic [7:0] FLIM = 8'(FILTER_LEN - 1);

    logic       s1, s2;
    logic [7:0] fcnt;

    // Two-stage synchroniser; raw never touches anything else.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Filtered value follows s2 only after it has differed FILTER_LEN cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fcnt <= 8'd0;
            filt <= 1'b0;
        end else if (s2 == filt) begin
            fcnt <= 8'd0;
        end else if (fcnt == FLIM) begin
            filt <= s2;
            fcnt <= 8'd0;
        end else begin
            fcnt <= fcnt + 8'd1;
        end
    end
endmodule

module quad_encoder_counter #(
    parameter int DATA_WIDTH = 32,
    parameter int FILTER_LEN = 4,
    parameter int ERR_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] mem_in,
    input  logic                  input_A,
    input  logic                  input_B,
    output logic [DATA_WIDTH-1:0] cnt_out,
    output logic                  dir,
    output logic [ERR_WIDTH-1:0]  err_cnt,
    output logic                  err_flag
);
    localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

    // Bit 1 = channel A, bit 0 = channel B.
    logic [1:0] raw_ab, cur, prev;
    logic       soft_rst, inv;
    logic       step_fwd, step_rev, illegal, legal, up;
    logic       unused_mem;

    assign raw_ab     = {input_A, input_B};
    assign soft_rst   = mem_in[DATA_WIDTH-1];
    assign inv        = mem_in[0];
    assign unused_mem = ^mem_in[DATA_WIDTH-2:1];

    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
        qec_chan_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
            .clk   (clk),
            .reset (reset),
            .raw   (raw_ab[ch]),
            .filt  (cur[ch])
        );
    end

    // Previous filtered state tracks every cycle, soft reset included, so
    // releasing soft reset never produces a step from stale state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) prev <= 2'b00;
        else        prev <= cur;
    end

    // Classify the prev->cur transition (forward = 00->01->11->10->00).
    always_comb begin
        step_fwd = 1'b0;
        step_rev = 1'b0;
        illegal  = 1'b0;
        case ({prev, cur})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step_fwd = 1'b1;
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step_rev = 1'b1;
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: illegal  = 1'b1;
            default: ;
        endcase
    end

    assign legal = step_fwd | step_rev;
    assign up    = step_fwd ^ inv;

    // Position counter and direction; soft reset overrides a coincident step.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_out <= '0;
            dir     <= 1'b0;
        end else if (soft_rst) begin
            cnt_out <= '0;
            dir     <= 1'b0;
        end else if (legal) begin
            cnt_out <= up ? cnt_out + ONE : cnt_out - ONE;
            dir     <= up;
        end
    end

    // Saturating illegal-transition counter and sticky flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_cnt  <= '0;
            err_flag <= 1'b0;
        end else if (soft_rst) begin
            err_cnt  <= '0;
            err_flag <= 1'b0;
        end else if (illegal) begin
            err_flag <= 1'b1;
            if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_quad_encoder_counter.sv
// Directed bench for quad_encoder_counter (FILTER_LEN=4, 32-bit count).
module tb_quad_encoder_counter;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mem_in;
    logic        input_A, input_B;
    logic [31:0] cnt_out;
    logic        dir;
    logic [7:0]  err_cnt;
    logic        err_flag;

    int checks   = 0;
    int failures = 0;
    int pos      = 0;

    quad_encoder_counter #(.DATA_WIDTH(32), .FILTER_LEN(4), .ERR_WIDTH(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .mem_in   (mem_in),
        .input_A  (input_A),
        .input_B  (input_B),
        .cnt_out  (cnt_out),
        .dir      (dir),
        .err_cnt  (err_cnt),
        .err_flag (err_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] gray(input int p);
        case (p & 3)
            0: gray = 2'b00;
            1: gray = 2'b01;
            2: gray = 2'b11;
            default: gray = 2'b10;
        endcase
    endfunction

    // Called at a negedge: apply levels, hold for 'hold' clocks.
    task automatic drive(input logic a, input logic b, input int hold);
        input_A = a;
        input_B = b;
        repeat (hold) @(negedge clk);
    endtask

    task automatic step(input bit fwd);
        logic [1:0] g;
        pos = fwd ? ((pos + 1) & 3) : ((pos + 3) & 3);
        g = gray(pos);
        drive(g[1], g[0], 10);
    endtask

    initial begin
        logic [1:0] g;
        reset = 1'b0; mem_in = 32'h0; input_A = 1'b0; input_B = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            input_A = i[0]; input_B = i[1];
            @(negedge clk);
        end
        chk("rst_cnt", cnt_out, 32'h0);
        chk("rst_dir", {31'b0, dir}, 32'h0);
        chk("rst_err", {24'b0, err_cnt}, 32'h0);
        chk("rst_flag", {31'b0, err_flag}, 32'h0);

        input_A = 1'b0; input_B = 1'b0;
        reset = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_cnt", cnt_out, 32'h0);
        chk("idle_err", {24'b0, err_cnt}, 32'h0);

        repeat (32) step(1'b1);
        chk("fwd32_cnt", cnt_out, 32'd32);
        chk("fwd32_dir", {31'b0, dir}, 32'h1);
        chk("fwd32_err", {24'b0, err_cnt}, 32'h0);
        repeat (12) step(1'b0);
        chk("rev12_cnt", cnt_out, 32'd20);
        chk("rev12_dir", {31'b0, dir}, 32'h0);

        // Latency: A rises (00->10, reverse); first sampled at edge k.
        input_A = 1'b1; pos = 3;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #1 chk("lat_k5", cnt_out, 32'd20);
        @(posedge clk);
        #1 chk("lat_k6", cnt_out, 32'd19);
        @(negedge clk);
        repeat (5) @(negedge clk);
        step(1'b1);
        chk("back20", cnt_out, 32'd20);

        // 3-cycle glitch on B must be filtered out.
        input_B = 1'b1;
        repeat (3) @(negedge clk);
        input_B = 1'b0;
        repeat (10) @(negedge clk);
        chk("glitch_cnt", cnt_out, 32'd20);
        chk("glitch_err", {24'b0, err_cnt}, 32'h0);

        // Illegal 00->11, then saturate the error counter.
        drive(1'b1, 1'b1, 10);
        chk("ill_cnt", cnt_out, 32'd20);
        chk("ill_err", {24'b0, err_cnt}, 32'd1);
        chk("ill_flag", {31'b0, err_flag}, 32'h1);
        chk("ill_dir", {31'b0, dir}, 32'h1);
        for (int i = 0; i < 299; i++) drive(~input_A, ~input_B, 10);
        chk("sat_err", {24'b0, err_cnt}, 32'd255);
        chk("sat_flag", {31'b0, err_flag}, 32'h1);
        chk("sat_cnt", cnt_out, 32'd20);

        // Positive wrap from preloaded max.
        force dut.cnt_out = 32'h7FFF_FFFF;
        @(negedge clk);
        release dut.cnt_out;
        @(negedge clk);
        step(1'b1);
        chk("wrap_pos", cnt_out, 32'h8000_0000);

        // Soft reset clears everything; then negative wrap from 0.
        mem_in = 32'h8000_0000;
        repeat (3) @(negedge clk);
        chk("sr_cnt", cnt_out, 32'h0);
        chk("sr_err", {24'b0, err_cnt}, 32'h0);
        chk("sr_flag", {31'b0, err_flag}, 32'h0);
        chk("sr_dir", {31'b0, dir}, 32'h0);
        mem_in = 32'h0;
        repeat (3) @(negedge clk);
        step(1'b0);
        chk("wrap_neg", cnt_out, 32'hFFFF_FFFF);
        step(1'b1);
        repeat (10) step(1'b1);
        chk("cnt10", cnt_out, 32'd10);

        // Step decoded while soft reset is high is discarded.
        pos = (pos + 1) & 3;
        g = gray(pos);
        input_A = g[1]; input_B = g[0];
        repeat (3) @(negedge clk);
        mem_in = 32'h8000_0000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("sr_step_cnt", cnt_out, 32'h0);
        end
        mem_in = 32'h0;
        repeat (10) @(negedge clk);
        chk("sr_release", cnt_out, 32'h0);
        step(1'b1);
        chk("after_sr", cnt_out, 32'd1);
        chk("after_sr_dir", {31'b0, dir}, 32'h1);

        // Inverted direction.
        mem_in = 32'h1;
        step(1'b1);
        chk("inv_cnt", cnt_out, 32'h0);
        chk("inv_dir", {31'b0, dir}, 32'h0);
        step(1'b0);
        chk("inv_rev", cnt_out, 32'd1);
        chk("inv_rev_dir", {31'b0, dir}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
